// File: rtl/gpu_cfg_master_if.sv
// Command and register-bus signals of the GPU config master.
// The master modport is the block; the slave modport is its host or peer.
interface gpu_cfg_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_type;
   logic [1:0] cmd_sel;
   logic       cmd_val;
   logic [3:0] cmd_wren;
   logic       reg_wr_cfg;
   logic [7:0] reg_wdata;
   logic       busy;
   logic       cmd_done;

   modport master (
      input  cmd_valid, cmd_type, cmd_sel, cmd_val, cmd_wren,
      output cmd_ready, reg_wr_cfg, reg_wdata, busy, cmd_done
   );

   modport slave (
      output cmd_valid, cmd_type, cmd_sel, cmd_val, cmd_wren,
      input  cmd_ready, reg_wr_cfg, reg_wdata, busy, cmd_done
   );
endinterface

// File: rtl/gpu_cfg_master.sv
// Queues host commands and replays each as an unlock-key sequence
// (0x19, 0x43, 0xFD) plus the command byte, one strobe every other cycle.
module gpu_cfg_master (
   input logic bus_clk,
   input logic bus_rst,
   gpu_cfg_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, K0, K1, K2, CMD, GAP} state_t;

   state_t     state, state_d;
   logic [1:0] phase, phase_d;
   logic [7:0] fifo [4];
   logic [1:0] wptr, rptr;
   logic [2:0] count, count_d;
   logic [7:0] cmd_reg;
   logic [7:0] enc;
   logic       push, pop;
   logic       wr_d, done_d;
   logic [7:0] wdata_d;

   assign push = bus.cmd_valid & bus.cmd_ready;
   assign enc  = bus.cmd_type ? {1'b1, bus.cmd_val, 4'b0000, bus.cmd_sel}
                              : {4'b0000, bus.cmd_wren};

   // Sequencer: phase remembers which key (or the command) follows a GAP.
   always_comb begin
      state_d = state;
      phase_d = phase;
      pop     = 1'b0;
      wr_d    = 1'b0;
      wdata_d = 8'h00;
      done_d  = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != 3'd0) begin
               pop     = 1'b1;
               state_d = K0;
            end
         end
         K0: begin
            wr_d    = 1'b1;
            wdata_d = 8'h19;
            phase_d = 2'd1;
            state_d = GAP;
         end
         K1: begin
            wr_d    = 1'b1;
            wdata_d = 8'h43;
            phase_d = 2'd2;
            state_d = GAP;
         end
         K2: begin
            wr_d    = 1'b1;
            wdata_d = 8'hFD;
            phase_d = 2'd3;
            state_d = GAP;
         end
         CMD: begin
            wr_d    = 1'b1;
            wdata_d = cmd_reg;
            done_d  = 1'b1;
            phase_d = 2'd0;
            state_d = GAP;
         end
         GAP: begin
            unique case (phase)
               2'd1:    state_d = K1;
               2'd2:    state_d = K2;
               2'd3:    state_d = CMD;
               default: state_d = IDLE;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   // Queue occupancy after this edge's push and pop.
   always_comb begin
      count_d = count;
      unique case ({push, pop})
         2'b10:   count_d = count + 3'd1;
         2'b01:   count_d = count - 3'd1;
         default: count_d = count;
      endcase
   end

   // State register; reset drops any partial sequence.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         state <= IDLE;
         phase <= 2'd0;
      end else begin
         state <= state_d;
         phase <= phase_d;
      end
   end

   // Command FIFO and the register holding the command being replayed.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         for (int i = 0; i < 4; i++) fifo[i] <= 8'h00;
         wptr    <= 2'd0;
         rptr    <= 2'd0;
         count   <= 3'd0;
         cmd_reg <= 8'h00;
      end else begin
         if (push) begin
            fifo[wptr] <= enc;
            wptr       <= wptr + 2'd1;
         end
         if (pop) begin
            cmd_reg <= fifo[rptr];
            rptr    <= rptr + 2'd1;
         end
         count <= count_d;
      end
   end

   // Registered outputs; ready tracks the post-edge occupancy.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         bus.reg_wr_cfg <= 1'b0;
         bus.reg_wdata  <= 8'h00;
         bus.cmd_done   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.cmd_ready  <= 1'b1;
      end else begin
         bus.reg_wr_cfg <= wr_d;
         bus.reg_wdata  <= wdata_d;
         bus.cmd_done   <= done_d;
         bus.busy       <= (count != 3'd0) | (state != IDLE);
         bus.cmd_ready  <= (count_d != 3'd4);
      end
   end
endmodule

// File: tb/tb_gpu_cfg_master.sv
// Directed bench for gpu_cfg_master: a strobe monitor with a receiver
// model, plus short command scenarios checked against hand values.
module tb_gpu_cfg_master;
   logic bus_clk = 1'b0;
   logic bus_rst;
   gpu_cfg_master_if bus ();

   gpu_cfg_master dut (
      .bus_clk (bus_clk),
      .bus_rst (bus_rst),
      .bus     (bus.master)
   );

   always #5 bus_clk = ~bus_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] log_data [$];
   int         log_cyc  [$];
   logic       log_done [$];
   logic [7:0] exp_q    [$];
   logic [7:0] keys     [3];

   logic       prev_wr;
   int         rx_step;
   logic [3:0] rx_cfg;
   logic [3:0] rx_wren;
   int         acc_cyc;
   int         waits;

   // Compare and report one value.
   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic t, input logic [1:0] s,
                                      input logic v, input logic [3:0] w);
      return t ? {1'b1, v, 4'b0000, s} : {4'b0000, w};
   endfunction

   always @(posedge bus_clk) cyc++;

   // Strobe monitor and receiver model of the GPU config FSM.
   always @(negedge bus_clk) begin
      if (bus_rst) begin
         rx_step = 0;
         rx_cfg  = 4'h0;
         rx_wren = 4'h0;
         prev_wr = 1'b0;
      end else begin
         if (bus.reg_wr_cfg) begin
            log_data.push_back(bus.reg_wdata);
            log_cyc.push_back(cyc);
            log_done.push_back(bus.cmd_done);
            chk("back_to_back", prev_wr, 1'b0);
            if (rx_step < 3) begin
               rx_step = (bus.reg_wdata == keys[rx_step]) ? rx_step + 1 : 0;
            end else begin
               if (bus.reg_wdata[7])
                  rx_cfg[bus.reg_wdata[1:0]] = bus.reg_wdata[6];
               else
                  rx_wren = bus.reg_wdata[3:0];
               rx_step = 0;
            end
         end else begin
            chk("wdata_idle", bus.reg_wdata, 8'h00);
            chk("done_idle", bus.cmd_done, 1'b0);
         end
         prev_wr = bus.reg_wr_cfg;
      end
   end

   task automatic tick();
      @(negedge bus_clk);
      #1;
   endtask

   task automatic push_cmd(input logic t, input logic [1:0] s,
                           input logic v, input logic [3:0] w);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_type  = t;
      bus.cmd_sel   = s;
      bus.cmd_val   = v;
      bus.cmd_wren  = w;
      while (!bus.cmd_ready && n < 200) begin
         tick();
         n++;
      end
      waits = n;
      if (n == 200) begin
         chk("push_timeout", n, 0);
      end else begin
         exp_q.push_back(enc(t, s, v, w));
         @(posedge bus_clk);
         #1;
         acc_cyc = cyc;
      end
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic clear_log();
      log_data.delete();
      log_cyc.delete();
      log_done.delete();
      exp_q.delete();
   endtask

   task automatic wait_strobes(input int n);
      int k = 0;
      while (log_data.size() < n && k < 1000) begin
         tick();
         k++;
      end
      if (k == 1000) chk("strobe_timeout", log_data.size(), n);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (bus.busy && k < 1000) begin
         tick();
         k++;
      end
      if (k == 1000) chk("idle_timeout", bus.busy, 1'b0);
   endtask

   // Each queued command must appear as keys then its byte, 2 cycles apart.
   task automatic check_seq(input string tag);
      chk({tag, "_len"}, log_data.size(), exp_q.size() * 4);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (4 * i + 3 < log_data.size()) begin
            for (int k = 0; k < 4; k++) begin
               chk({tag, "_byte"}, log_data[4*i+k],
                   (k == 3) ? exp_q[i] : keys[k]);
               chk({tag, "_gap"}, log_cyc[4*i+k], log_cyc[4*i] + 2 * k);
               chk({tag, "_done"}, log_done[4*i+k], k == 3);
            end
         end
      end
   endtask

   initial begin
      keys[0] = 8'h19;
      keys[1] = 8'h43;
      keys[2] = 8'hFD;
      bus_rst       = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_type  = 1'b0;
      bus.cmd_sel   = 2'd0;
      bus.cmd_val   = 1'b0;
      bus.cmd_wren  = 4'h0;
      tick();
      tick();
      chk("rst_ready", bus.cmd_ready, 1'b1);
      chk("rst_wr", bus.reg_wr_cfg, 1'b0);
      chk("rst_wdata", bus.reg_wdata, 8'h00);
      chk("rst_done", bus.cmd_done, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      bus_rst = 1'b0;

      // Single config command: scale 2x on.
      clear_log();
      push_cmd(1'b1, 2'd0, 1'b1, 4'h0);
      chk("t1_nowait", waits, 0);
      wait_strobes(4);
      wait_idle();
      check_seq("t1");
      if (log_data.size() >= 4) begin
         chk("t1_latency", log_cyc[0], acc_cyc + 2);
         chk("t1_b4", log_data[3], 8'hC0);
      end
      chk("t1_scale2x", rx_cfg[0], 1'b1);

      // Write-enable command 0xA.
      clear_log();
      push_cmd(1'b0, 2'd0, 1'b0, 4'hA);
      wait_strobes(4);
      wait_idle();
      check_seq("t2");
      if (log_data.size() >= 4) chk("t2_b4", log_data[3], 8'h0A);
      chk("t2_wren", rx_wren, 4'hA);

      // Fill: five back-to-back pushes, the first already in flight.
      clear_log();
      push_cmd(1'b1, 2'd1, 1'b1, 4'h0);
      push_cmd(1'b0, 2'd0, 1'b0, 4'h3);
      push_cmd(1'b1, 2'd2, 1'b1, 4'h0);
      push_cmd(1'b0, 2'd0, 1'b0, 4'hC);
      push_cmd(1'b1, 2'd3, 1'b0, 4'h0);
      chk("fill_5th_nowait", waits, 0);
      chk("fill_ready_low", bus.cmd_ready, 1'b0);
      chk("fill_busy", bus.busy, 1'b1);
      wait_strobes(20);
      tick();
      chk("fill_busy_gap", bus.busy, 1'b1);
      tick();
      chk("fill_busy_fall", bus.busy, 1'b0);
      check_seq("fill");
      if (log_data.size() >= 20) begin
         for (int i = 0; i < 4; i++)
            chk("fill_b2b", log_cyc[4*i+4], log_cyc[4*i+3] + 3);
      end
      chk("fill_hscan", rx_cfg[1], 1'b1);
      chk("fill_vscan", rx_cfg[2], 1'b1);
      chk("fill_wren", rx_wren, 4'hC);

      // Push and pop on the same edge with three queued.
      clear_log();
      push_cmd(1'b0, 2'd0, 1'b0, 4'h1);
      push_cmd(1'b0, 2'd0, 1'b0, 4'h2);
      push_cmd(1'b0, 2'd0, 1'b0, 4'h3);
      push_cmd(1'b0, 2'd0, 1'b0, 4'h4);
      wait_strobes(4);
      tick();
      push_cmd(1'b0, 2'd0, 1'b0, 4'h5);
      chk("pp_nowait", waits, 0);
      chk("pp_ready", bus.cmd_ready, 1'b1);
      push_cmd(1'b0, 2'd0, 1'b0, 4'h6);
      chk("pp_full", bus.cmd_ready, 1'b0);
      wait_strobes(24);
      wait_idle();
      check_seq("pp");

      // Reset in the gap after the second key with two commands queued.
      clear_log();
      push_cmd(1'b1, 2'd3, 1'b1, 4'h0);
      push_cmd(1'b0, 2'd0, 1'b0, 4'h7);
      push_cmd(1'b0, 2'd0, 1'b0, 4'h8);
      wait_strobes(2);
      if (log_data.size() >= 2) chk("rst_k1", log_data[1], 8'h43);
      tick();
      bus_rst = 1'b1;
      #1;
      chk("mid_rst_wr", bus.reg_wr_cfg, 1'b0);
      chk("mid_rst_wdata", bus.reg_wdata, 8'h00);
      chk("mid_rst_done", bus.cmd_done, 1'b0);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_ready", bus.cmd_ready, 1'b1);
      tick();
      tick();
      bus_rst = 1'b0;
      clear_log();
      push_cmd(1'b0, 2'd0, 1'b0, 4'h9);
      chk("post_rst_nowait", waits, 0);
      for (int i = 0; i < 20; i++) tick();
      wait_idle();
      check_seq("post_rst");

      // Eight random commands, spacing watched by the monitor.
      clear_log();
      for (int i = 0; i < 8; i++) begin
         push_cmd(1'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
      end
      wait_strobes(32);
      wait_idle();
      check_seq("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
